// File: rtl/icache_refill_axi_pkg.sv
// Shared types and AXI encodings for the instruction-cache line refill path.
// The 256-bit line is assembled from eight 32-bit INCR beats.
package icache_refill_axi_pkg;

   typedef logic [255:0] bus256_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      DONE = 2'd3
   } refill_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Byte address of the first word of a 32-byte line.
   function automatic logic [31:0] line_base(input logic [26:0] line_addr);
      return {line_addr, 5'b0_0000};
   endfunction

endpackage

// File: rtl/icache_refill_axi_if.sv
// AXI4 read address and read data channels used by the refill engine.
// master = refill engine side, slave = memory/interconnect side.
interface icache_refill_axi_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/icache_refill_axi_line_assembler.sv
// Beat counter plus BEATS x 32-bit line buffer with one write enable per word.
// The counter saturates on the last slot so surplus beats overwrite the final word.
module icache_refill_axi_line_assembler #(
   parameter int unsigned BEATS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  we,
   input  logic [31:0]           wdata,
   output logic                  last_slot,
   output logic [BEATS*32-1:0]   line
);

   localparam int unsigned CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      word_q [BEATS];
   logic [31:0]      word_d [BEATS];
   logic [BEATS-1:0] word_we_s;

   // Per-word write enables, next buffer contents and counter advance.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < BEATS; i++) begin
         word_we_s[i] = we && (cnt_q == CNT_W'(i));
         if (word_we_s[i]) begin
            word_d[i] = wdata;
         end else begin
            word_d[i] = word_q[i];
         end
      end
      if (clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (we && (cnt_q != LAST_CNT)) begin
         cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and buffer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
         for (int i = 0; i < BEATS; i++) begin
            word_q[i] <= 32'h0000_0000;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < BEATS; i++) begin
            word_q[i] <= word_d[i];
         end
      end
   end

   // The line view already includes the beat being written this cycle.
   always_comb begin
      last_slot = (cnt_q == LAST_CNT);
      for (int i = 0; i < BEATS; i++) begin
         line[i*32 +: 32] = word_d[i];
      end
   end

endmodule

// File: rtl/icache_refill_axi.sv
// Instruction-cache refill responder: one AXI4 INCR burst per line request,
// beats assembled into a 256-bit line returned with a registered ret_valid pulse.
module icache_refill_axi
   import icache_refill_axi_pkg::*;
#(
   parameter logic [3:0]  AXI_ID = 4'h0,
   parameter int unsigned BEATS  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rd_req,
   input  logic [31:0]                rd_addr,
   output logic                       ret_valid,
   output bus256_t                    ret_data,
   icache_refill_axi_if.master        axi,
   output logic                       busy,
   output logic                       bus_err
);

   refill_state_t state_q, state_d;
   logic [26:0]   line_addr_q, line_addr_d;
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic          busy_q, busy_d;
   logic          ret_valid_q, ret_valid_d;
   logic          bus_err_q, bus_err_d;
   bus256_t       ret_data_q, ret_data_d;

   logic          ar_hs_s;
   logic          beat_s;
   logic          last_slot_s;
   bus256_t       line_s;
   logic          rd_addr_unused_s;

   assign rd_addr_unused_s = ^rd_addr[4:0];

   assign ar_hs_s = arvalid_q && axi.arready;
   assign beat_s  = rready_q && axi.rvalid;

   icache_refill_axi_line_assembler #(
      .BEATS (BEATS)
   ) u_line_assembler (
      .clk       (clk),
      .reset     (reset),
      .clr       (ar_hs_s),
      .we        (beat_s),
      .wdata     (axi.rdata),
      .last_slot (last_slot_s),
      .line      (line_s)
   );

   // Next-state and next-output logic for the refill FSM.
   always_comb begin
      state_d     = state_q;
      line_addr_d = line_addr_q;
      ret_valid_d = 1'b0;
      bus_err_d   = 1'b0;
      ret_data_d  = ret_data_q;
      case (state_q)
         IDLE: begin
            if (rd_req) begin
               line_addr_d = rd_addr[31:5];
               state_d     = AR;
            end else begin
               state_d = IDLE;
            end
         end
         AR: begin
            if (ar_hs_s) begin
               state_d = R;
            end else begin
               state_d = AR;
            end
         end
         R: begin
            if (beat_s) begin
               // rlast must coincide exactly with the final word slot.
               bus_err_d = (axi.rresp != AXI_RESP_OKAY) ||
                           (axi.rid != AXI_ID) ||
                           (axi.rlast != last_slot_s);
               if (axi.rlast) begin
                  state_d     = DONE;
                  ret_valid_d = rd_req && (rd_addr[31:5] == line_addr_q);
                  ret_data_d  = line_s;
               end else begin
                  state_d = R;
               end
            end else begin
               state_d = R;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      arvalid_d = (state_d == AR);
      rready_d  = (state_d == R);
      busy_d    = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         line_addr_q <= 27'h000_0000;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         busy_q      <= 1'b0;
         ret_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
         ret_data_q  <= 256'h0;
      end else begin
         state_q     <= state_d;
         line_addr_q <= line_addr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         busy_q      <= busy_d;
         ret_valid_q <= ret_valid_d;
         bus_err_q   <= bus_err_d;
         ret_data_q  <= ret_data_d;
      end
   end

   assign axi.arid    = AXI_ID;
   assign axi.araddr  = line_base(line_addr_q);
   assign axi.arlen   = 8'(BEATS - 1);
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   assign ret_valid = ret_valid_q;
   assign ret_data  = ret_data_q;
   assign busy      = busy_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_icache_refill_axi.sv
// Directed + randomized bench for icache_refill_axi; the reference is a word-array
// memory model and a line-buffer model updated beat by beat.
module tb_icache_refill_axi;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         ret_valid;
   logic [255:0] ret_data;
   logic         busy;
   logic         bus_err;

   icache_refill_axi_if axi ();

   icache_refill_axi dut (
      .clk       (clk),
      .reset     (reset),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .ret_valid (ret_valid),
      .ret_data  (ret_data),
      .axi       (axi),
      .busy      (busy),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   int unsigned  n_pass = 0;
   int unsigned  n_total = 0;
   int unsigned  cycle = 0;
   int unsigned  err_cycles = 0;
   int unsigned  ret_count = 0;
   int unsigned  t0, err0, ret0;
   logic         data_mode;
   logic [31:0]  seed;
   logic [31:0]  model_buf [8];

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (bus_err === 1'b1) err_cycles <= err_cycles + 1;
      if (ret_valid === 1'b1) ret_count <= ret_count + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] lbase(input logic [31:0] a);
      return {a[31:5], 5'b0_0000};
   endfunction

   // Memory contents: index pattern for the basic case, otherwise a seeded hash.
   function automatic logic [31:0] beat_data(input logic [31:0] base, input int b);
      logic [31:0] a;
      a = base + 32'(b * 4);
      if (data_mode) return 32'(b);
      return (a * 32'h9E37_79B1) ^ seed;
   endfunction

   function automatic logic [255:0] model_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = model_buf[i];
      return l;
   endfunction

   task automatic snap();
      t0   = cycle;
      err0 = err_cycles;
      ret0 = ret_count;
   endtask

   task automatic begin_txn(input logic [31:0] a);
      rd_req  = 1'b1;
      rd_addr = a;
      snap();
      tick();
   endtask

   task automatic wait_ar(output int waited);
      waited = 0;
      while (axi.arvalid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check("arvalid_seen", axi.arvalid, 1'b1);
   endtask

   task automatic do_ar(input logic [31:0] exp_addr, input int hold);
      check("araddr", axi.araddr, exp_addr);
      check("ar_attrs", {axi.arid, axi.arlen, axi.arsize, axi.arburst},
            {4'h0, 8'd7, 3'b010, 2'b01});
      for (int i = 0; i < hold; i++) begin
         axi.arready = 1'b0;
         tick();
         check("arvalid_hold", axi.arvalid, 1'b1);
         check("araddr_hold", axi.araddr, exp_addr);
      end
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      check("arvalid_drop", axi.arvalid, 1'b0);
   endtask

   task automatic send_beats(input logic [31:0] base, input int nbeats, input int last_at,
                             input int unsigned gmin, input int unsigned gmax,
                             input int err_beat, input int bad_rid_beat,
                             input int chg_at, input logic chg_req, input logic [31:0] chg_addr);
      int unsigned g;
      logic [31:0] w;
      for (int b = 0; b < nbeats; b++) begin
         g = $urandom_range(gmax, gmin);
         if (b == chg_at) begin
            rd_req  = chg_req;
            rd_addr = chg_addr;
         end
         for (int k = 0; k < int'(g); k++) begin
            axi.rvalid = 1'b0;
            tick();
         end
         w = beat_data(base, b);
         axi.rvalid = 1'b1;
         axi.rdata  = w;
         axi.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
         axi.rid    = (b == bad_rid_beat) ? 4'h5 : 4'h0;
         axi.rlast  = (b == last_at);
         check("rready_in_r", axi.rready, 1'b1);
         model_buf[(b < 7) ? b : 7] = w;
         tick();
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
      axi.rid    = 4'h0;
   endtask

   // Called one cycle after the rlast beat.
   task automatic finish_txn(input logic exp_ret, input int exp_err);
      check("ret_valid", ret_valid, exp_ret);
      if (exp_ret) begin
         check("ret_data", ret_data, model_line());
         rd_req = 1'b0;
      end
      tick();
      check("ret_valid_clear", ret_valid, 1'b0);
      check("busy_idle", busy, 1'b0);
      check("bus_err_cycles", err_cycles - err0, exp_err);
      check("ret_pulses", ret_count - ret0, exp_ret ? 1 : 0);
   endtask

   initial begin
      int w;
      logic [31:0] a;
      reset = 1'b1;
      rd_req = 1'b0;
      rd_addr = 32'h0;
      axi.arready = 1'b0;
      axi.rvalid = 1'b0;
      axi.rdata = 32'h0;
      axi.rresp = 2'b00;
      axi.rlast = 1'b0;
      axi.rid = 4'h0;
      data_mode = 1'b0;
      seed = $urandom;
      repeat (3) tick();
      check("rst_arvalid", axi.arvalid, 1'b0);
      check("rst_rready", axi.rready, 1'b0);
      check("rst_ret_valid", ret_valid, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ret_data", ret_data, 256'h0);
      reset = 1'b0;
      tick();

      // Basic zero-wait refill; counting the rd_req cycle as cycle 1, ret_valid lands in cycle 11.
      data_mode = 1'b1;
      begin_txn(32'h1C00_0034);
      wait_ar(w);
      check("ar_latency", w, 0);
      do_ar(32'h1C00_0020, 0);
      send_beats(32'h1C00_0020, 8, 7, 0, 0, -1, -1, -1, 1'b1, 32'h1C00_0034);
      check("latency_cycles", cycle - t0, 10);
      check("basic_word0", ret_data[31:0], 32'h0);
      check("basic_word7", ret_data[255:224], 32'h7);
      finish_txn(1'b1, 0);
      data_mode = 1'b0;

      // Address backpressure and beats on every other cycle.
      a = $urandom;
      begin_txn(a);
      wait_ar(w);
      do_ar(lbase(a), 3);
      send_beats(lbase(a), 8, 7, 1, 1, -1, -1, -1, 1'b1, a);
      finish_txn(1'b1, 0);

      // Request withdrawn mid-burst.
      a = $urandom;
      begin_txn(a);
      wait_ar(w);
      do_ar(lbase(a), 1);
      send_beats(lbase(a), 8, 7, 0, 1, -1, -1, 3, 1'b0, a);
      finish_txn(1'b0, 0);
      tick();
      check("wd_arvalid", axi.arvalid, 1'b0);
      check("wd_busy", busy, 1'b0);

      // Request retargeted mid-burst: line dropped, new burst after a 2-cycle gap.
      begin_txn(32'h1C00_0034);
      wait_ar(w);
      do_ar(32'h1C00_0020, 0);
      send_beats(32'h1C00_0020, 8, 7, 0, 0, -1, -1, 4, 1'b1, 32'h1C00_1000);
      finish_txn(1'b0, 0);
      wait_ar(w);
      check("rt_gap", w, 1);
      snap();
      do_ar(32'h1C00_1000, 0);
      send_beats(32'h1C00_1000, 8, 7, 0, 1, -1, -1, -1, 1'b1, 32'h1C00_1000);
      finish_txn(1'b1, 0);

      // SLVERR on beat 3: error pulse, line still returned.
      a = $urandom;
      begin_txn(a);
      wait_ar(w);
      do_ar(lbase(a), 0);
      send_beats(lbase(a), 8, 7, 0, 0, 3, -1, -1, 1'b1, a);
      finish_txn(1'b1, 1);

      // Wrong RID on beat 6.
      a = $urandom;
      begin_txn(a);
      wait_ar(w);
      do_ar(lbase(a), 0);
      send_beats(lbase(a), 8, 7, 0, 0, -1, 6, -1, 1'b1, a);
      finish_txn(1'b1, 1);

      // Early rlast on beat 5: words 6 and 7 keep the previous line.
      a = $urandom;
      begin_txn(a);
      wait_ar(w);
      do_ar(lbase(a), 0);
      send_beats(lbase(a), 6, 5, 0, 0, -1, -1, -1, 1'b1, a);
      finish_txn(1'b1, 1);

      // Missing rlast on beat 7: ninth beat overwrites word 7 and closes the burst.
      a = $urandom;
      begin_txn(a);
      wait_ar(w);
      do_ar(lbase(a), 0);
      send_beats(lbase(a), 9, 8, 0, 0, -1, -1, -1, 1'b1, a);
      finish_txn(1'b1, 1);

      // rvalid while idle is ignored.
      snap();
      axi.rvalid = 1'b1;
      axi.rlast = 1'b1;
      axi.rresp = 2'b10;
      axi.rid = 4'h3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_rready", axi.rready, 1'b0);
         check("idle_busy", busy, 1'b0);
      end
      axi.rvalid = 1'b0;
      axi.rlast = 1'b0;
      axi.rresp = 2'b00;
      axi.rid = 4'h0;
      tick();
      check("idle_rvalid_err", err_cycles - err0, 0);
      check("idle_rvalid_ret", ret_count - ret0, 0);

      // Reset after four beats, then a fresh burst.
      a = $urandom;
      begin_txn(a);
      wait_ar(w);
      do_ar(lbase(a), 0);
      send_beats(lbase(a), 4, -1, 0, 0, -1, -1, -1, 1'b1, a);
      reset = 1'b1;
      tick();
      check("mrst_arvalid", axi.arvalid, 1'b0);
      check("mrst_rready", axi.rready, 1'b0);
      check("mrst_ret_valid", ret_valid, 1'b0);
      check("mrst_busy", busy, 1'b0);
      reset = 1'b0;
      a = $urandom;
      rd_addr = a;
      snap();
      wait_ar(w);
      do_ar(lbase(a), 0);
      send_beats(lbase(a), 8, 7, 0, 0, -1, -1, -1, 1'b1, a);
      finish_txn(1'b1, 0);

      // Randomized addresses, address waits and beat gaps.
      for (int k = 0; k < 6; k++) begin
         a = $urandom;
         begin_txn(a);
         wait_ar(w);
         do_ar(lbase(a), int'($urandom_range(3, 0)));
         send_beats(lbase(a), 8, 7, 0, 2, -1, -1, -1, 1'b1, a);
         finish_txn(1'b1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/icache_refill_axi.md
Name: icache_refill_axi

Overview:
- Memory-side responder for the instruction-cache refill interface.
- Accepts a line request on rd_req/rd_addr and issues one AXI4 INCR read burst of 8×32-bit beats.
- Assembles the beats into a 256-bit line and returns it with a single-cycle ret_valid pulse.
- Sits between the icache and the AXI read channel; one outstanding transaction at a time.

Parameters:
- AXI_ID, 4'h0, fixed ARID used for all refill bursts.
- BEATS, 8, beats per line; line is BEATS×32 bits (the 8-beat, 256-bit line is the supported configuration).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  refill request; held high by requester until ret_valid
- rd_addr  in  32  request address; bits [4:0] ignored
- ret_valid  out  1  one-cycle pulse; ret_data valid this cycle
- ret_data  out  256  line data; word i at bits [32i+31:32i]; word 0 at line base
- arid  out  4  = AXI_ID
- araddr  out  32  {latched line addr[31:5], 5'b0}
- arlen  out  8  = 7
- arsize  out  3  = 3'b010
- arburst  out  2  = 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address ready
- rid  in  4  read ID
- rdata  in  32  read beat data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  beat valid
- rready  out  1  beat ready
- busy  out  1  high in any state except IDLE
- bus_err  out  1  one-cycle pulse on protocol or response error

Behaviour:
- Reset values: state IDLE; arvalid, rready, ret_valid, bus_err, busy all 0; ret_data 0; beat counter 0.
- ret_valid is a register. It must not depend combinationally on rd_req, because the requester derives rd_req from ret_valid.
- State IDLE:
  - If rd_req is high, latch line_addr <= rd_addr[31:5] and go to AR.
  - rd_req is sampled only in IDLE.
- State AR:
  - arvalid = 1; araddr, arlen, arsize, arburst and arid are stable.
  - On arvalid && arready: go to R and clear the beat counter.
  - arvalid never drops before the handshake.
- State R:
  - rready = 1.
  - Each rvalid beat writes rdata into word[cnt] of the line buffer, then cnt++.
  - On the beat with rlast = 1, go to DONE, and in the same edge:
    - set ret_valid <= rd_req && (rd_addr[31:5] == line_addr);
    - otherwise discard the line: the request was withdrawn or retargeted.
- State DONE (exactly one cycle):
  - ret_valid as set above; ret_data = assembled buffer.
  - Next state IDLE; ret_valid clears.
  - A request still pending is re-sampled in IDLE on the following cycle, which gives a minimum 2-cycle gap between bursts.
- Errors (all pulse bus_err for one cycle; the burst still runs to rlast):
  - rresp != 2'b00 on any beat; the line is still returned.
  - rid != AXI_ID.
  - rlast with cnt != 7.
  - cnt == 7 without rlast: the counter saturates, extra beats overwrite word 7, and state waits for rlast.
- Latency: rd_req rising in IDLE → arvalid next cycle. Last beat at cycle t → ret_valid at t+1. Zero-wait total is 11 cycles from rd_req to ret_valid.
- rvalid while not in R: ignored; rready = 0.
- Reset mid-burst returns to IDLE immediately. The system resets the AXI slave concurrently, so no drain is required.
- ret_data holds its last value outside DONE.

Decomposition:
- pipeline_types package gets:
  - bus256_t (already present);
  - refill_state_t enum {IDLE, AR, R, DONE};
  - constants AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY.
- One natural sub-module: line_assembler (beat counter plus 8×32 buffer with write-enable per word).

Test Plan:
- Basic refill: rd_req=1, rd_addr=0x1C00_0034, arready=1, 8 zero-wait beats 0x0..0x7 → araddr=0x1C00_0020, arlen=7, ret_valid pulses once at cycle 11, ret_data[31:0]=0, ret_data[255:224]=7.
- Backpressure: arready low 3 cycles; rvalid gapped every other cycle → arvalid and araddr stable until handshake; ret_valid one cycle after rlast; data order preserved.
- Withdrawn request: drop rd_req mid-burst → ret_valid stays 0; FSM returns to IDLE; no bus_err.
- Retargeted request: rd_addr changes to 0x1C00_1000 mid-burst → first line discarded; second burst issues araddr=0x1C00_1000.
- Errors:
  - rresp=2'b10 on beat 3 → bus_err single pulse, ret_valid still asserted;
  - rlast on beat 5 → bus_err, DONE entered.
- Reset mid-R (after 4 beats) → next cycle: arvalid=0, rready=0, ret_valid=0, busy=0; a new rd_req starts a fresh burst.
